// File: rtl/melody_sequencer.sv
// Steps through note entries in a synchronous song ROM and drives the buzzer tone
// generator, timing each note in beats and following it with a silent gap.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_000_000,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic [ADDR_W-1:0] song_base,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [9:0]        mem_data,
    output logic [1:0]        shift,
    output logic [2:0]        note,
    output logic              en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_idx
);

    localparam int CW = $clog2(BEAT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] base;
    logic              rest;
    logic [3:0]        dur;
    logic [3:0]        beat_cnt;
    logic [CW-1:0]     cyc_cnt;
    logic [GW-1:0]     gap_cnt;

    logic take_start, addr_base, addr_inc, ld_entry;
    logic play_end, gap_end;

    assign play_end = (cyc_cnt == BEAT_LAST) && (beat_cnt == dur - 4'd1);
    assign gap_end  = (gap_cnt == GAP_LAST);
    assign busy     = (state != IDLE);
    assign note_idx = mem_addr - base;
    // en follows the current state only; stop takes effect at the next edge
    assign en       = (state == PLAY) && !rest && !pause;

    always_comb begin
        state_d    = state;
        done       = 1'b0;
        take_start = 1'b0;
        addr_base  = 1'b0;
        addr_inc   = 1'b0;
        ld_entry   = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    take_start = 1'b1;
                    state_d    = FETCH;
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (mem_data[3:0] == 4'd0) begin
                        if (loop) begin
                            addr_base = 1'b1;
                            state_d   = FETCH;
                        end else begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        ld_entry = 1'b1;
                        state_d  = PLAY;
                    end
                end
                PLAY: if (!pause && play_end) state_d = GAP;
                GAP: if (!pause && gap_end) begin
                    // last ROM address ends the song rather than wrapping to 0
                    if (&mem_addr) begin
                        if (loop) begin
                            addr_base = 1'b1;
                            state_d   = FETCH;
                        end else begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        addr_inc = 1'b1;
                        state_d  = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base     <= '0;
            mem_addr <= '0;
            shift    <= '0;
            note     <= '0;
            rest     <= 1'b0;
            dur      <= '0;
            beat_cnt <= '0;
            cyc_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            state <= state_d;
            if (take_start) begin
                base     <= song_base;
                mem_addr <= song_base;
            end
            if (addr_base) mem_addr <= base;
            if (addr_inc)  mem_addr <= mem_addr + ADDR_W'(1);
            if (ld_entry) begin
                shift    <= mem_data[9:8];
                note     <= mem_data[7:5];
                rest     <= mem_data[4];
                dur      <= mem_data[3:0];
                beat_cnt <= '0;
                cyc_cnt  <= '0;
                gap_cnt  <= '0;
            end
            if (state == PLAY && !pause) begin
                if (cyc_cnt == BEAT_LAST) begin
                    cyc_cnt  <= '0;
                    beat_cnt <= beat_cnt + 4'd1;
                end else begin
                    cyc_cnt <= cyc_cnt + CW'(1);
                end
            end
            if (state == GAP && !pause) gap_cnt <= gap_cnt + GW'(1);
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: expected output events (busy/en edges, done pulses) are queued with
// their cycle offset from the accepted start; a negedge monitor pops and compares them.
module tb_melody_sequencer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
    logic [AW-1:0] song_base = '0;
    logic [AW-1:0] mem_addr;
    logic [9:0]    mem_data;
    logic [1:0]    shift;
    logic [2:0]    note;
    logic          en, busy, done;
    logic [AW-1:0] note_idx;

    melody_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(2), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .loop(loop),
        .song_base(song_base), .mem_addr(mem_addr), .mem_data(mem_data), .shift(shift),
        .note(note), .en(en), .busy(busy), .done(done), .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    logic [9:0] rom [16];
    always_ff @(posedge clk) mem_data <= rom[mem_addr];

    typedef enum logic [2:0] {EV_BRISE, EV_RISE, EV_FALL, EV_DONE, EV_BFALL} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [15:0] rel;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } ev_t;

    ev_t exp_q[$];
    int  compares = 0;
    int  fails = 0;
    int  cyc = 0;
    int  t0 = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [9:0] ent(input logic [1:0] s, input logic [2:0] n,
                                       input logic r, input logic [3:0] d);
        return {s, n, r, d};
    endfunction

    task automatic push(input ev_kind_t k, input int rel, input int d0, input int d1);
        ev_t e;
        e.kind = k;
        e.rel  = 16'(rel);
        e.d0   = 8'(d0);
        e.d1   = 8'(d1);
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input logic [15:0] rel,
                           input logic [7:0] d0, input logic [7:0] d1);
        ev_t e;
        compares++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d rel=%0d d0=%0d d1=%0d, none expected",
                     k, rel, d0, d1);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.rel !== rel || e.d0 !== d0 || e.d1 !== d1) begin
                fails++;
                $display("FAIL event: got kind=%0d rel=%0d d0=%0d d1=%0d, want kind=%0d rel=%0d d0=%0d d1=%0d",
                         k, rel, d0, d1, e.kind, e.rel, e.d0, e.d1);
            end
        end
    endtask

    // monitor: turns output transitions into events and checks them against the queue
    initial begin
        logic p_busy, p_en;
        logic [15:0] rel;
        p_busy = 1'b0;
        p_en   = 1'b0;
        forever begin
            @(negedge clk);
            rel = 16'(cyc - t0);
            if (busy && !p_busy) observe(EV_BRISE, rel, 8'(mem_addr), 8'(note_idx));
            if (en && !p_en)     observe(EV_RISE, rel, 8'(shift), 8'(note));
            if (!en && p_en)     observe(EV_FALL, rel, 8'd0, 8'd0);
            if (done)            observe(EV_DONE, rel, 8'd0, 8'd0);
            if (!busy && p_busy) observe(EV_BFALL, rel, 8'(mem_addr), 8'(note_idx));
            p_busy = busy;
            p_en   = en;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_en"}, int'(en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_shift"}, int'(shift), 0);
        chk({tag, "_note"}, int'(note), 0);
        chk({tag, "_note_idx"}, int'(note_idx), 0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = '0;
    endtask

    task automatic start_song(input logic [AW-1:0] b);
        @(posedge clk);
        #1 song_base = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            compares++;
            fails++;
            $display("FAIL drain_timeout: got %0d events outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        clear_rom();
        #2 chk_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // stop beats start in IDLE: nothing may happen
        @(posedge clk);
        #1 start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("stop_prio_busy", int'(busy), 0);

        // basic two-note song
        clear_rom();
        rom[0] = ent(2'd0, 3'd2, 1'b0, 4'd2);
        rom[1] = ent(2'd1, 3'd5, 1'b0, 4'd1);
        push(EV_BRISE, 0, 0, 0);
        push(EV_RISE, 2, 0, 2);
        push(EV_FALL, 10, 0, 0);
        push(EV_RISE, 14, 1, 5);
        push(EV_FALL, 18, 0, 0);
        push(EV_DONE, 21, 0, 0);
        push(EV_BFALL, 22, 2, 2);
        start_song(4'd0);
        drain(60);

        // rest entry, plus a start while busy that must be ignored
        clear_rom();
        rom[0] = ent(2'd2, 3'd0, 1'b1, 4'd3);
        rom[1] = ent(2'd0, 3'd3, 1'b0, 4'd1);
        push(EV_BRISE, 0, 0, 0);
        push(EV_RISE, 18, 0, 3);
        push(EV_FALL, 22, 0, 0);
        push(EV_DONE, 25, 0, 0);
        push(EV_BFALL, 26, 2, 2);
        start_song(4'd0);
        repeat (5) @(posedge clk);
        #1 song_base = 4'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain(60);

        // pause for 5 cycles from PLAY cycle 3 of a one-beat note
        clear_rom();
        rom[0] = ent(2'd1, 3'd6, 1'b0, 4'd1);
        push(EV_BRISE, 0, 0, 0);
        push(EV_RISE, 2, 1, 6);
        push(EV_FALL, 4, 0, 0);
        push(EV_RISE, 9, 1, 6);
        push(EV_FALL, 11, 0, 0);
        push(EV_DONE, 14, 0, 0);
        push(EV_BFALL, 15, 1, 1);
        start_song(4'd0);
        repeat (4) @(posedge clk);
        #1 pause = 1'b1;
        repeat (5) @(posedge clk);
        #1 pause = 1'b0;
        drain(60);

        // stop mid-PLAY, then restart from base 5
        clear_rom();
        rom[0] = ent(2'd0, 3'd7, 1'b0, 4'd3);
        rom[5] = ent(2'd3, 3'd4, 1'b0, 4'd1);
        push(EV_BRISE, 0, 0, 0);
        push(EV_RISE, 2, 0, 7);
        push(EV_FALL, 6, 0, 0);
        push(EV_BFALL, 6, 0, 0);
        start_song(4'd0);
        repeat (5) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        drain(30);
        push(EV_BRISE, 0, 5, 0);
        push(EV_RISE, 2, 3, 4);
        push(EV_FALL, 6, 0, 0);
        push(EV_DONE, 9, 0, 0);
        push(EV_BFALL, 10, 6, 1);
        start_song(4'd5);
        drain(40);

        // loop a one-note song: 10-cycle period, no done
        clear_rom();
        rom[0] = ent(2'd1, 3'd1, 1'b0, 4'd1);
        push(EV_BRISE, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            push(EV_RISE, 2 + 10 * k, 1, 1);
            push(EV_FALL, 6 + 10 * k, 0, 0);
        end
        push(EV_BFALL, 28, 0, 0);
        loop = 1'b1;
        start_song(4'd0);
        repeat (27) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        loop = 1'b0;
        drain(40);

        // last ROM address ends the song; address 0 must not be fetched
        clear_rom();
        rom[15] = ent(2'd0, 3'd1, 1'b0, 4'd1);
        rom[0]  = ent(2'd3, 3'd7, 1'b0, 4'd1);
        push(EV_BRISE, 0, 15, 0);
        push(EV_RISE, 2, 0, 1);
        push(EV_FALL, 6, 0, 0);
        push(EV_DONE, 7, 0, 0);
        push(EV_BFALL, 8, 15, 0);
        start_song(4'd15);
        drain(40);

        // async reset in GAP, then play from a new base
        clear_rom();
        rom[0] = ent(2'd0, 3'd2, 1'b0, 4'd2);
        rom[3] = ent(2'd2, 3'd6, 1'b0, 4'd1);
        push(EV_BRISE, 0, 0, 0);
        push(EV_RISE, 2, 0, 2);
        push(EV_FALL, 10, 0, 0);
        push(EV_BFALL, 11, 0, 0);
        start_song(4'd0);
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero_outputs("async_rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drain(10);
        push(EV_BRISE, 0, 3, 0);
        push(EV_RISE, 2, 2, 6);
        push(EV_FALL, 6, 0, 0);
        push(EV_DONE, 9, 0, 0);
        push(EV_BFALL, 10, 4, 1);
        start_song(4'd3);
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
